status_unit: RTL and testbench
==============================

STATUS_UNIT -- requirements
Module: status_unit

Interface
REQ-001 Parameter WIDTH, default 32: ALU datapath width; sizes resultIn only.
REQ-002 Parameter DEPTH, default 4: flag save-stack entries; legal range 2..16.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 statusIn  input  4  ALU status word, indexed ST_NEG, ST_ZERO, ST_CARRY, ST_OVERFLOW.
REQ-006 resultIn  input  WIDTH  ALU result; observed only when recomputeZ=1.
REQ-007 statusValid  input  1  statusIn is valid this cycle; request a flag update.
REQ-008 updateMask  input  4  per-flag write enable, same bit indices as statusIn.
REQ-009 recomputeZ  input  1  derive Z from (resultIn == 0) instead of statusIn[ST_ZERO].
REQ-010 condReq  input  1  request evaluation of condCode.
REQ-011 condCode  input  4  condition selector, encoding per REQ-018.
REQ-012 push  input  1  save the current flags onto the stack.
REQ-013 pop  input  1  restore the flags from the top of the stack.
REQ-014 flags  output  4  architectural flag register.
REQ-015 condValid  output  1  condTrue is valid this cycle.
REQ-016 condTrue  output  1  evaluated condition result.
REQ-017 stackEmpty, stackFull, stackErr  output  1 each  stack empty, stack full, sticky misuse flag.

Function
REQ-018 Condition encoding: 0 EQ=Z, 1 NE=!Z, 2 CS=C, 3 CC=!C, 4 MI=N, 5 PL=!N, 6 VS=V, 7 VC=!V, 8 HI=C&!Z, 9 LS=!C|Z, 10 GE=(N==V), 11 LT=(N!=V), 12 GT=!Z&(N==V), 13 LE=Z|(N!=V), 14 AL=1, 15 NV=0.
REQ-019 Next-flag priority is pop (when legal), then masked statusValid update, then hold.
REQ-020 Masked update: flags[i] <= statusIn[i] where updateMask[i]=1; all other flag bits are held.
REQ-021 When recomputeZ=1 with a masked Z update, the Z source is (resultIn == 0).
REQ-022 When a legal pop and statusValid occur in the same cycle, the status update is discarded.
REQ-023 Condition evaluation uses the next-flag value, forwarding a same-cycle update or pop.
REQ-024 condValid and condTrue are registered one cycle after condReq; condValid=0 and condTrue=0 in all other cycles.
REQ-025 Back-to-back condReq gives one result per cycle; there is no stall.
REQ-026 A push saves the registered (pre-update) flags; the stack pointer increments.
REQ-027 A pop loads the top entry into flags; the stack pointer decrements.
REQ-028 Push when full, or pop when empty: no state change other than stackErr being set to 1.
REQ-029 push and pop together: both ignored, no stack or flag change, stackErr unchanged.
REQ-030 stackErr stays set until reset.
REQ-031 stackEmpty = (count == 0); stackFull = (count == DEPTH); both are derived from the registered count.

Reset
REQ-032 While rst=1, on the clock edge: flags=4'b0000, count=0, condValid=0, condTrue=0, stackErr=0.
REQ-033 Reset has priority over every concurrent request; a request asserted in a reset cycle is lost.
REQ-034 Stack contents are not reset and are unobservable after reset.

Structure
REQ-035 Shared package alu_pkg holds ST_NEG=3, ST_ZERO=2, ST_CARRY=1, ST_OVERFLOW=0 and the 16 condition-code constants.
REQ-036 The ALU op blocks and status_unit import the same alu_pkg constants.
REQ-037 Condition decode is a combinational sub-module cond_eval (inputs: 4-bit flags, condCode; output: condTrue).
REQ-038 status_unit registers the cond_eval output.
REQ-039 Target size is 120-400 lines of RTL in total.

Verification
REQ-040 Masked update and zero recompute:
- Step 1: statusValid, statusIn=4'b1111, updateMask=4'b0101 -> flags=4'b0101 next cycle.
- Step 2: recomputeZ=1, resultIn=0, updateMask=4'b0100 -> flags[ST_ZERO]=1.
REQ-041 Forwarding: flags=0; in the same cycle statusValid (Z=1, mask=4'b0100) and condReq with condCode=0 (EQ) -> condValid=1, condTrue=1 one cycle later.
REQ-042 Sweep all 16 condCodes over all 16 flag values -> condTrue matches the REQ-018 table; AL always 1, NV always 0.
REQ-043 Stack limits (DEPTH=4):
- 4 pushes of distinct flags -> stackFull=1.
- 5th push -> stackErr=1, count stays 4.
- 4 pops restore the flags in LIFO order -> stackEmpty=1.
- 5th pop -> flags unchanged.
REQ-044 Simultaneous events:
- Legal pop with statusValid -> flags equal the popped value.
- push with pop -> no change.
REQ-045 Reset mid-operation: 2 entries pushed, condReq pending, rst=1 for one cycle -> flags=0, stackEmpty=1, condValid=0, stackErr=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU constants: status-word bit positions and condition-code encodings.
// Imported by the ALU op blocks, status_unit and cond_eval so they agree on layout.
package alu_pkg;

    localparam int unsigned ST_NEG      = 3;
    localparam int unsigned ST_ZERO     = 2;
    localparam int unsigned ST_CARRY    = 1;
    localparam int unsigned ST_OVERFLOW = 0;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code decoder: evaluates condCode against a 4-bit flag word.
module cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] condCode,
    output logic       condTrue
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;

    assign n_flag = flags[ST_NEG];
    assign z_flag = flags[ST_ZERO];
    assign c_flag = flags[ST_CARRY];
    assign v_flag = flags[ST_OVERFLOW];

    always_comb begin
        condTrue = 1'b0;
        case (condCode)
            COND_EQ: condTrue = z_flag;
            COND_NE: condTrue = ~z_flag;
            COND_CS: condTrue = c_flag;
            COND_CC: condTrue = ~c_flag;
            COND_MI: condTrue = n_flag;
            COND_PL: condTrue = ~n_flag;
            COND_VS: condTrue = v_flag;
            COND_VC: condTrue = ~v_flag;
            COND_HI: condTrue = c_flag & ~z_flag;
            COND_LS: condTrue = ~c_flag | z_flag;
            COND_GE: condTrue = (n_flag == v_flag);
            COND_LT: condTrue = (n_flag != v_flag);
            COND_GT: condTrue = ~z_flag & (n_flag == v_flag);
            COND_LE: condTrue = z_flag | (n_flag != v_flag);
            COND_AL: condTrue = 1'b1;
            COND_NV: condTrue = 1'b0;
            default: condTrue = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_unit.sv
// ALU status/flag unit: masked flag updates, registered condition evaluation and a
// small LIFO save stack for the flag word with sticky misuse detection.
module status_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       statusIn,
    input  logic [WIDTH-1:0] resultIn,
    input  logic             statusValid,
    input  logic [3:0]       updateMask,
    input  logic             recomputeZ,
    input  logic             condReq,
    input  logic [3:0]       condCode,
    input  logic             push,
    input  logic             pop,
    output logic [3:0]       flags,
    output logic             condValid,
    output logic             condTrue,
    output logic             stackEmpty,
    output logic             stackFull,
    output logic             stackErr
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned IdxW = $clog2(DEPTH);

    logic [3:0]      flags_q, flags_d;
    logic [CntW-1:0] count_q, count_d;
    logic [3:0]      stack_q [DEPTH];
    logic [3:0]      stack_d [DEPTH];
    logic            cond_valid_q, cond_valid_d;
    logic            cond_true_q, cond_true_d;
    logic            stack_err_q, stack_err_d;

    logic            stack_empty;
    logic            stack_full;
    logic            push_only;
    logic            pop_only;
    logic            push_ok;
    logic            pop_ok;
    logic            stack_misuse;
    logic [IdxW-1:0] wr_idx;
    logic [IdxW-1:0] rd_idx;
    logic [3:0]      status_eff;
    logic [3:0]      flags_upd;
    logic            cond_hit;

    assign stack_empty = (count_q == '0);
    assign stack_full  = (count_q == CntW'(DEPTH));

    // Simultaneous push and pop cancel each other and are not counted as misuse.
    assign push_only    = push & ~pop;
    assign pop_only     = pop & ~push;
    assign push_ok      = push_only & ~stack_full;
    assign pop_ok       = pop_only & ~stack_empty;
    assign stack_misuse = (push_only & stack_full) | (pop_only & stack_empty);

    assign wr_idx = IdxW'(count_q);
    assign rd_idx = IdxW'(count_q - CntW'(1));

    always_comb begin
        status_eff = statusIn;
        if (recomputeZ) begin
            status_eff[ST_ZERO] = (resultIn == '0);
        end
    end

    assign flags_upd = (flags_q & ~updateMask) | (status_eff & updateMask);

    always_comb begin
        flags_d      = flags_q;
        count_d      = count_q;
        stack_d      = stack_q;
        stack_err_d  = stack_err_q | stack_misuse;
        if (pop_ok) begin
            flags_d = stack_q[rd_idx];
            count_d = count_q - CntW'(1);
        end else if (statusValid) begin
            flags_d = flags_upd;
        end
        // The saved word is the registered value, not this cycle's update.
        if (push_ok) begin
            stack_d[wr_idx] = flags_q;
            count_d         = count_q + CntW'(1);
        end
    end

    // Decode against flags_d so a same-cycle update or pop is forwarded.
    cond_eval u_cond_eval (
        .flags    (flags_d),
        .condCode (condCode),
        .condTrue (cond_hit)
    );

    always_comb begin
        cond_valid_d = condReq;
        cond_true_d  = condReq & cond_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q      <= 4'b0000;
            count_q      <= '0;
            cond_valid_q <= 1'b0;
            cond_true_q  <= 1'b0;
            stack_err_q  <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            count_q      <= count_d;
            cond_valid_q <= cond_valid_d;
            cond_true_q  <= cond_true_d;
            stack_err_q  <= stack_err_d;
        end
    end

    // Stack storage carries no reset; entries above count are never read.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign flags      = flags_q;
    assign condValid  = cond_valid_q;
    assign condTrue   = cond_true_q;
    assign stackEmpty = stack_empty;
    assign stackFull  = stack_full;
    assign stackErr   = stack_err_q;

endmodule

// File: tb/tb_status_unit.sv
// Directed self-checking bench for status_unit with hand-computed expectations.
module tb_status_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  statusIn;
    logic [31:0] resultIn;
    logic        statusValid;
    logic [3:0]  updateMask;
    logic        recomputeZ;
    logic        condReq;
    logic [3:0]  condCode;
    logic        push;
    logic        pop;
    logic [3:0]  flags;
    logic        condValid;
    logic        condTrue;
    logic        stackEmpty;
    logic        stackFull;
    logic        stackErr;

    int n_checks;
    int n_pass;

    status_unit #(
        .WIDTH (32),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .statusIn    (statusIn),
        .resultIn    (resultIn),
        .statusValid (statusValid),
        .updateMask  (updateMask),
        .recomputeZ  (recomputeZ),
        .condReq     (condReq),
        .condCode    (condCode),
        .push        (push),
        .pop         (pop),
        .flags       (flags),
        .condValid   (condValid),
        .condTrue    (condTrue),
        .stackEmpty  (stackEmpty),
        .stackFull   (stackFull),
        .stackErr    (stackErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        rst         = 1'b0;
        statusIn    = 4'b0000;
        resultIn    = 32'd0;
        statusValid = 1'b0;
        updateMask  = 4'b0000;
        recomputeZ  = 1'b0;
        condReq     = 1'b0;
        condCode    = 4'd0;
        push        = 1'b0;
        pop         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply a full-mask status write (optionally with push) for one cycle.
    task automatic set_flags(input logic [3:0] val, input logic with_push);
        statusValid = 1'b1;
        updateMask  = 4'b1111;
        statusIn    = val;
        push        = with_push;
        tick();
        idle();
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        idle();
    endtask

    // Bit order of f: N Z C V.
    function automatic logic cond_model(input logic [3:0] f, input logic [3:0] code);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (code)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle();

        // Reset state
        rst = 1'b1;
        tick();
        idle();
        check("rst_flags", 8'(flags), 8'h0);
        check("rst_empty", 8'(stackEmpty), 8'h1);
        check("rst_full", 8'(stackFull), 8'h0);
        check("rst_err", 8'(stackErr), 8'h0);
        check("rst_cvalid", 8'(condValid), 8'h0);
        check("rst_ctrue", 8'(condTrue), 8'h0);

        // Masked update
        statusValid = 1'b1;
        statusIn    = 4'b1111;
        updateMask  = 4'b0101;
        tick();
        idle();
        check("mask_0101", 8'(flags), 8'h5);

        // Zero recompute: statusIn Z=0 but result is zero
        statusValid = 1'b1;
        recomputeZ  = 1'b1;
        resultIn    = 32'd0;
        statusIn    = 4'b0000;
        updateMask  = 4'b0100;
        tick();
        idle();
        check("recomp_z1", 8'(flags), 8'h5);

        // Zero recompute: statusIn Z=1 but result is non-zero
        statusValid = 1'b1;
        recomputeZ  = 1'b1;
        resultIn    = 32'h8000_0000;
        statusIn    = 4'b0100;
        updateMask  = 4'b0110;
        tick();
        idle();
        check("recomp_z0", 8'(flags), 8'h1);

        // statusValid with empty mask holds flags
        statusValid = 1'b1;
        statusIn    = 4'b1110;
        updateMask  = 4'b0000;
        tick();
        idle();
        check("mask_none", 8'(flags), 8'h1);

        // Forwarding a same-cycle Z update into EQ
        set_flags(4'b0000, 1'b0);
        check("fwd_pre", 8'(flags), 8'h0);
        statusValid = 1'b1;
        statusIn    = 4'b0100;
        updateMask  = 4'b0100;
        condReq     = 1'b1;
        condCode    = 4'd0;
        tick();
        idle();
        check("fwd_cvalid", 8'(condValid), 8'h1);
        check("fwd_ctrue", 8'(condTrue), 8'h1);
        tick();
        check("fwd_cvalid_drop", 8'(condValid), 8'h0);
        check("fwd_ctrue_drop", 8'(condTrue), 8'h0);

        // Sweep all codes over all flag values, back to back
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                statusValid = 1'b1;
                updateMask  = 4'b1111;
                statusIn    = 4'(f);
                condReq     = 1'b1;
                condCode    = 4'(c);
                tick();
                check($sformatf("sweep_v_f%0d_c%0d", f, c), 8'(condValid), 8'h1);
                check($sformatf("sweep_t_f%0d_c%0d", f, c), 8'(condTrue),
                      8'(cond_model(4'(f), 4'(c))));
            end
        end
        idle();
        tick();

        // Stack fill: each push saves the pre-update flags
        set_flags(4'b0001, 1'b0);
        set_flags(4'b0010, 1'b1);
        set_flags(4'b0100, 1'b1);
        set_flags(4'b1000, 1'b1);
        check("fill3_full", 8'(stackFull), 8'h0);
        set_flags(4'b1111, 1'b1);
        check("fill4_full", 8'(stackFull), 8'h1);
        check("fill4_empty", 8'(stackEmpty), 8'h0);
        check("fill4_err", 8'(stackErr), 8'h0);
        push = 1'b1;
        tick();
        idle();
        check("over_err", 8'(stackErr), 8'h1);
        check("over_full", 8'(stackFull), 8'h1);
        check("over_flags", 8'(flags), 8'hF);

        do_pop();
        check("pop1", 8'(flags), 8'h8);
        check("pop1_full", 8'(stackFull), 8'h0);
        do_pop();
        check("pop2", 8'(flags), 8'h4);
        do_pop();
        check("pop3", 8'(flags), 8'h2);
        check("pop3_empty", 8'(stackEmpty), 8'h0);
        do_pop();
        check("pop4", 8'(flags), 8'h1);
        check("pop4_empty", 8'(stackEmpty), 8'h1);
        do_pop();
        check("under_flags", 8'(flags), 8'h1);
        check("under_err", 8'(stackErr), 8'h1);
        check("under_empty", 8'(stackEmpty), 8'h1);

        // Simultaneous events
        set_flags(4'b1001, 1'b0);
        push = 1'b1;
        tick();
        idle();
        set_flags(4'b0011, 1'b0);
        push = 1'b1;
        pop  = 1'b1;
        tick();
        idle();
        check("pushpop_flags", 8'(flags), 8'h3);
        check("pushpop_empty", 8'(stackEmpty), 8'h0);
        pop         = 1'b1;
        statusValid = 1'b1;
        updateMask  = 4'b1111;
        statusIn    = 4'b1100;
        tick();
        idle();
        check("popsv_flags", 8'(flags), 8'h9);
        check("popsv_empty", 8'(stackEmpty), 8'h1);

        // Reset mid-operation
        set_flags(4'b0101, 1'b1);
        set_flags(4'b0110, 1'b1);
        check("mid_pre_empty", 8'(stackEmpty), 8'h0);
        rst      = 1'b1;
        condReq  = 1'b1;
        condCode = 4'd14;
        tick();
        idle();
        check("mid_flags", 8'(flags), 8'h0);
        check("mid_empty", 8'(stackEmpty), 8'h1);
        check("mid_cvalid", 8'(condValid), 8'h0);
        check("mid_ctrue", 8'(condTrue), 8'h0);
        check("mid_err", 8'(stackErr), 8'h0);
        tick();
        check("mid_req_lost", 8'(condValid), 8'h0);

        // push+pop on empty stack is ignored and does not flag misuse
        push = 1'b1;
        pop  = 1'b1;
        tick();
        idle();
        check("pp_empty_err", 8'(stackErr), 8'h0);
        check("pp_empty_empty", 8'(stackEmpty), 8'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
